// File: rtl/lcd5110_pkg.sv
// Shared types and constants for the PCD8544 (Nokia 5110) LCD front-end.
package lcd5110_pkg;

    typedef enum logic [2:0] {
        RST_LOW,
        RST_WAIT,
        INIT,
        IDLE,
        ADDR,
        FRAME,
        DONE
    } lcd_state_e;

    localparam logic [7:0] CMD_FUNC_EXT    = 8'h21;
    localparam logic [7:0] CMD_VOP         = 8'hB1;
    localparam logic [7:0] CMD_TEMP        = 8'h04;
    localparam logic [7:0] CMD_BIAS        = 8'h14;
    localparam logic [7:0] CMD_FUNC_BASIC  = 8'h20;
    localparam logic [7:0] CMD_DISP_NORMAL = 8'h0C;
    localparam logic [7:0] CMD_SET_X0      = 8'h80;
    localparam logic [7:0] CMD_SET_Y0      = 8'h40;

    localparam int INIT_BYTES  = 6;
    localparam int FRAME_BYTES = 504;

    function automatic logic [7:0] init_cmd(input logic [2:0] i);
        case (i)
            3'd0:    return CMD_FUNC_EXT;
            3'd1:    return CMD_VOP;
            3'd2:    return CMD_TEMP;
            3'd3:    return CMD_BIAS;
            3'd4:    return CMD_FUNC_BASIC;
            default: return CMD_DISP_NORMAL;
        endcase
    endfunction

endpackage

// File: rtl/spi_byte_tx.sv
// One-byte SPI mode-0 transmitter: sce framing, MSB first, CLK_DIV-cycle half periods,
// CLK_DIV-cycle sce-high gap after each byte.
module spi_byte_tx #(
    parameter int CLK_DIV = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] byte_in,
    input  logic       dc_in,
    output logic       busy,
    output logic       byte_done,
    output logic       sce,
    output logic       dc,
    output logic       mosi,
    output logic       sck
);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_cnt;
    logic [3:0]    half_cnt;
    logic [7:0]    shreg;
    logic          active;
    logic          gap;
    logic          div_wrap;

    assign div_wrap  = (div_cnt == DIV_LAST);
    // The last gap cycle already accepts the next byte so slots pack back to back.
    assign byte_done = gap & div_wrap;
    assign busy      = active & ~byte_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active   <= 1'b0;
            gap      <= 1'b0;
            div_cnt  <= '0;
            half_cnt <= '0;
            shreg    <= '0;
            sce      <= 1'b1;
            dc       <= 1'b0;
            mosi     <= 1'b0;
            sck      <= 1'b0;
        end else if (start && !busy) begin
            active   <= 1'b1;
            gap      <= 1'b0;
            div_cnt  <= '0;
            half_cnt <= '0;
            shreg    <= byte_in;
            sce      <= 1'b0;
            dc       <= dc_in;
            mosi     <= byte_in[7];
            sck      <= 1'b0;
        end else if (active) begin
            if (div_wrap) begin
                div_cnt <= '0;
                if (gap) begin
                    active <= 1'b0;
                    gap    <= 1'b0;
                end else if (half_cnt == 4'd15) begin
                    sck <= 1'b0;
                    sce <= 1'b1;
                    gap <= 1'b1;
                end else begin
                    half_cnt <= half_cnt + 4'd1;
                    sck      <= ~sck;
                    // mosi advances only on falling sck
                    if (sck) begin
                        mosi  <= shreg[6];
                        shreg <= {shreg[6:0], 1'b0};
                    end
                end
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/draw_with_switches.sv
// Nokia 5110 front-end: LCD reset/init sequence, then a full 504-byte frame
// patterned from the switches on each accepted draw edge.
module draw_with_switches
    import lcd5110_pkg::*;
#(
    parameter int CLK_DIV         = 16,
    parameter int RST_LOW_CYCLES  = 10000,
    parameter int RST_WAIT_CYCLES = 10000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] switches,
    input  logic        draw,
    output logic        done,
    output logic        rst_lcd,
    output logic        sce,
    output logic        dc,
    output logic        mosi,
    output logic        sck
);
    localparam int DLY_MAX = (RST_LOW_CYCLES > RST_WAIT_CYCLES) ? RST_LOW_CYCLES : RST_WAIT_CYCLES;
    localparam int CW      = $clog2(DLY_MAX + 1);

    lcd_state_e       state, state_nxt;
    logic [CW-1:0]    dly_cnt, dly_nxt;
    logic [8:0]       idx, idx_nxt;
    logic [1:0]       draw_sync;
    logic             draw_prev;
    logic [1:0][15:0] sw_sync;
    logic [15:0]      pattern;
    logic             draw_rise;
    logic             tx_start, tx_busy, tx_done, tx_dc;
    logic [7:0]       tx_byte;

    assign draw_rise = draw_sync[1] & ~draw_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            draw_sync <= '0;
            draw_prev <= 1'b0;
            sw_sync   <= '0;
            pattern   <= '0;
        end else begin
            draw_sync <= {draw_sync[0], draw};
            draw_prev <= draw_sync[1];
            sw_sync   <= {sw_sync[0], switches};
            if (state == IDLE && draw_rise)
                pattern <= sw_sync[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RST_LOW;
            dly_cnt <= '0;
            idx     <= '0;
            rst_lcd <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            dly_cnt <= dly_nxt;
            idx     <= idx_nxt;
            rst_lcd <= (state_nxt != RST_LOW);
            done    <= (state_nxt == DONE);
        end
    end

    // Byte phases advance on tx_done; idx counts bytes within the current phase.
    always_comb begin
        state_nxt = state;
        dly_nxt   = dly_cnt;
        idx_nxt   = idx;
        case (state)
            RST_LOW:
                if (dly_cnt == CW'(RST_LOW_CYCLES - 1)) begin
                    state_nxt = RST_WAIT;
                    dly_nxt   = '0;
                end else begin
                    dly_nxt = dly_cnt + 1'b1;
                end
            RST_WAIT:
                if (dly_cnt == CW'(RST_WAIT_CYCLES - 1)) begin
                    state_nxt = INIT;
                    dly_nxt   = '0;
                end else begin
                    dly_nxt = dly_cnt + 1'b1;
                end
            INIT:
                if (tx_done) begin
                    if (idx == 9'(INIT_BYTES - 1)) begin
                        state_nxt = IDLE;
                        idx_nxt   = '0;
                    end else begin
                        idx_nxt = idx + 9'd1;
                    end
                end
            IDLE:
                if (draw_rise)
                    state_nxt = ADDR;
            ADDR:
                if (tx_done) begin
                    if (idx == 9'd1) begin
                        state_nxt = FRAME;
                        idx_nxt   = '0;
                    end else begin
                        idx_nxt = idx + 9'd1;
                    end
                end
            FRAME:
                if (tx_done) begin
                    if (idx == 9'(FRAME_BYTES - 1)) begin
                        state_nxt = DONE;
                        idx_nxt   = '0;
                    end else begin
                        idx_nxt = idx + 9'd1;
                    end
                end
            DONE:
                state_nxt = IDLE;
            default:
                state_nxt = RST_LOW;
        endcase
    end

    // Next byte is chosen from the upcoming state/index so it launches in the
    // same cycle the previous slot ends.
    always_comb begin
        tx_byte  = 8'h00;
        tx_dc    = 1'b0;
        tx_start = 1'b0;
        case (state_nxt)
            INIT: begin
                tx_byte  = init_cmd(idx_nxt[2:0]);
                tx_start = ~tx_busy;
            end
            ADDR: begin
                tx_byte  = idx_nxt[0] ? CMD_SET_Y0 : CMD_SET_X0;
                tx_start = ~tx_busy;
            end
            FRAME: begin
                tx_byte  = idx_nxt[0] ? pattern[7:0] : pattern[15:8];
                tx_dc    = 1'b1;
                tx_start = ~tx_busy;
            end
            default: ;
        endcase
    end

    spi_byte_tx #(
        .CLK_DIV (CLK_DIV)
    ) u_tx (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (tx_start),
        .byte_in   (tx_byte),
        .dc_in     (tx_dc),
        .busy      (tx_busy),
        .byte_done (tx_done),
        .sce       (sce),
        .dc        (dc),
        .mosi      (mosi),
        .sck       (sck)
    );

endmodule

// File: tb/tb_draw_with_switches.sv
// Directed bench for draw_with_switches: decodes the SPI stream from the pins and
// compares it, plus reset/timing behaviour, against hand-computed values.
module tb_draw_with_switches;
    localparam int CLK_DIV = 2;
    localparam int RL      = 20;
    localparam int RW      = 20;
    localparam int SLOT    = 17 * CLK_DIV;

    logic        clk, rst_n, draw, done, rst_lcd, sce, dc, mosi, sck;
    logic [15:0] switches;

    draw_with_switches #(
        .CLK_DIV         (CLK_DIV),
        .RST_LOW_CYCLES  (RL),
        .RST_WAIT_CYCLES (RW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .switches (switches),
        .draw     (draw),
        .done     (done),
        .rst_lcd  (rst_lcd),
        .sce      (sce),
        .dc       (dc),
        .mosi     (mosi),
        .sck      (sck)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0;
    int cyc = 0, tick = 0;
    int done_cnt = 0, done_cyc = 0, done_run = 0, done_max = 0;
    int proto_bad = 0, period_bad = 0;
    logic [8:0] cap_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_bytes(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (cap_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (cap_q.size() < n) chk(tag, cap_q.size(), n);
    endtask

    task automatic wait_done(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (done_cnt < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (done_cnt < n) chk(tag, done_cnt, n);
    endtask

    task automatic chk_init(input int base, input string tag);
        logic [7:0] cmds [6];
        cmds = '{8'h21, 8'hB1, 8'h04, 8'h14, 8'h20, 8'h0C};
        for (int i = 0; i < 6; i++)
            chk($sformatf("%s[%0d]", tag, i), 32'(cap_q[base + i]), {23'd0, 1'b0, cmds[i]});
    endtask

    task automatic pulse_draw(input int len);
        @(posedge clk); #1 draw = 1'b1;
        repeat (len) @(posedge clk);
        #1 draw = 1'b0;
    endtask

    always @(posedge clk) cyc++;

    // Pin-level SPI decoder and protocol watcher, sampled on the falling clock edge.
    initial begin
        logic p_sck, p_sce, p_mosi, cur_dc;
        logic [7:0] sh;
        int bitcnt, last_t;
        p_sck = 1'b0; p_sce = 1'b1; p_mosi = 1'b0; cur_dc = 1'b0;
        sh = '0; bitcnt = 0; last_t = 0;
        forever begin
            @(negedge clk);
            tick++;
            if (!sce && p_sce) begin
                bitcnt = 0;
                last_t = tick;
            end
            if (sck && !p_sck) begin
                if (sce) proto_bad++;
                if (mosi != p_mosi) proto_bad++;
                if (tick - last_t != ((bitcnt == 0) ? CLK_DIV : 2 * CLK_DIV)) period_bad++;
                last_t = tick;
                sh     = {sh[6:0], mosi};
                cur_dc = dc;
                bitcnt++;
            end
            if (sck && p_sck && mosi != p_mosi) proto_bad++;
            if (sce && sck) proto_bad++;
            if (sce && !p_sce && bitcnt == 8) cap_q.push_back({cur_dc, sh});
            if (done) begin
                done_run++;
                if (done_run == 1) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                if (done_run > done_max) done_max = done_run;
            end else begin
                done_run = 0;
            end
            p_sck = sck; p_sce = sce; p_mosi = mosi;
        end
    end

    initial begin
        int n, c0, base;
        rst_n = 1'b0; draw = 1'b0; switches = 16'h0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rst_lcd", rst_lcd, 0);
        chk("rst_sce", sce, 1);
        chk("rst_dc", dc, 0);
        chk("rst_mosi", mosi, 0);
        chk("rst_sck", sck, 0);
        chk("rst_done", done, 0);

        @(posedge clk); #1 rst_n = 1'b1;
        // request during RST_WAIT must be dropped
        fork
            begin
                repeat (25) @(posedge clk);
                #1 draw = 1'b1;
                repeat (4) @(posedge clk);
                #1 draw = 1'b0;
            end
        join_none

        n = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (rst_lcd) break;
            n++;
        end
        chk("rst_low_len", n, RL);
        n = 1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (!sce) break;
            n++;
        end
        chk("rst_wait_len", n, RW);

        pulse_draw(4);  // during INIT, dropped
        wait_bytes(6, 2000, "init_tmo");
        chk_init(0, "init");
        repeat (50) @(negedge clk);
        chk("no_frame_from_init_draw", cap_q.size(), 6);
        chk("no_done_from_init_draw", done_cnt, 0);

        // frame 1: 0x8000, level held long, mid-frame switch change and extra request
        @(posedge clk); #1 switches = 16'h8000; draw = 1'b1; c0 = cyc;
        repeat (100) @(posedge clk);
        #1 draw = 1'b0;
        wait_bytes(6 + 2 + 100, 20000, "f1_mid_tmo");
        #1 switches = 16'hFFFF;
        pulse_draw(4);
        wait_done(1, 30000, "f1_done_tmo");
        chk("f1_latency", done_cyc - c0, 3 + 506 * SLOT);
        repeat (50) @(negedge clk);
        chk("f1_bytes", cap_q.size(), 6 + 506);
        chk("f1_done_cnt", done_cnt, 1);
        base = 6;
        chk("f1_addr_x", 32'(cap_q[base]), 32'h080);
        chk("f1_addr_y", 32'(cap_q[base + 1]), 32'h040);
        for (int i = 0; i < 504; i++)
            chk($sformatf("f1_data[%0d]", i), 32'(cap_q[base + 2 + i]),
                (i % 2 == 0) ? 32'h180 : 32'h100);

        // frame 2: switches now 0xFFFF
        base = cap_q.size();
        pulse_draw(10);
        wait_done(2, 30000, "f2_done_tmo");
        repeat (50) @(negedge clk);
        chk("f2_bytes", cap_q.size(), base + 506);
        chk("f2_addr_x", 32'(cap_q[base]), 32'h080);
        chk("f2_addr_y", 32'(cap_q[base + 1]), 32'h040);
        for (int i = 0; i < 504; i++)
            chk($sformatf("f2_data[%0d]", i), 32'(cap_q[base + 2 + i]), 32'h1FF);

        // frame 3: reset after data byte 200
        base = cap_q.size();
        @(posedge clk); #1 switches = 16'h1234;
        repeat (4) @(posedge clk);
        pulse_draw(6);
        wait_bytes(base + 202, 20000, "f3_mid_tmo");
        chk("f3_data0", 32'(cap_q[base + 2]), 32'h112);
        chk("f3_data1", 32'(cap_q[base + 3]), 32'h134);
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        chk("midrst_sce", sce, 1);
        chk("midrst_sck", sck, 0);
        chk("midrst_rst_lcd", rst_lcd, 0);
        chk("midrst_done", done, 0);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_bytes(base + 208, 3000, "reinit_tmo");
        chk_init(base + 202, "reinit");
        repeat (50) @(negedge clk);
        chk("reinit_bytes", cap_q.size(), base + 208);
        chk("total_done", done_cnt, 2);
        chk("done_width", done_max, 1);
        chk("spi_protocol", proto_bad, 0);
        chk("sck_period", period_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/draw_with_switches.md
# draw_with_switches

Nokia 5110 / PCD8544 (84x48) LCD front-end. After reset it runs the LCD power-up reset and init command sequence, then waits for a `draw` request. On request it streams a full 504-byte frame whose pattern comes from the 16 `switches`, over a 3-wire SPI (`sce`, `dc`, `mosi`, `sck`). It sits between board switches/button and the LCD header, and is the static-screen core of `wb_static_screen`.

## Interface
- `CLK_DIV`, 16: system-clock cycles per `sck` half-period (sck = clk/32, 3.125 MHz at 100 MHz).
- `RST_LOW_CYCLES`, 10000: cycles `rst_lcd` is held low after reset.
- `RST_WAIT_CYCLES`, 10000: cycles after `rst_lcd` rises before init bytes.
- `clk`  in  1  system clock (100 MHz), all logic rising-edge.
- `rst_n`  in  1  reset; one clock, asynchronous, active-low.
- `switches`  in  16  screen pattern, asynchronous board input.
- `draw`  in  1  draw request (button level, asynchronous).
- `done`  out  1  one-cycle pulse when a frame transmission completes.
- `rst_lcd`  out  1  LCD reset, active-low.
- `sce`  out  1  LCD chip enable, active-low.
- `dc`  out  1  0 = command byte, 1 = data byte.
- `mosi`  out  1  serial data, MSB first.
- `sck`  out  1  serial clock, idle low.

## Operation
- Reset values: `rst_lcd`=0, `sce`=1, `dc`=0, `mosi`=0, `sck`=0, `done`=0. FSM in `RST_LOW`.
- States:
  - `RST_LOW`: hold `rst_lcd`=0 for `RST_LOW_CYCLES`.
  - `RST_WAIT`: `rst_lcd`=1 for `RST_WAIT_CYCLES`.
  - `INIT`: send commands (`dc`=0) 0x21, 0xB1, 0x04, 0x14, 0x20, 0x0C.
  - `IDLE`: wait for `draw`.
  - `ADDR`: send commands 0x80 (X=0), 0x40 (Y=0).
  - `FRAME`: send 504 data bytes (`dc`=1).
  - `DONE`: pulse `done` for one cycle, then return to `IDLE`.
- `draw` passes through a 2-flop synchronizer. Only a rising edge seen in `IDLE` starts a frame. Edges seen in any other state are dropped, not queued. A level held high does not retrigger.
- On the accepted edge, `switches` (2-flop synchronized) is latched into `pattern`. It is stable for the whole frame.
- Data byte index i = 0..503: byte = `pattern[15:8]` if i even, `pattern[7:0]` if i odd.
- Byte counter is 9 bits and terminates at 503. Nothing wraps past it.

## Timing
- SPI mode 0:
  - `sce` falls, and `dc` and `mosi` (bit 7) become valid, one half-period before the first `sck` rise.
  - `mosi` changes only on `sck` falling edges. The LCD samples on rising edges.
- Byte slot: 8 bits × 2×`CLK_DIV` cycles. `sce` returns high with `sck` low, and stays high for `CLK_DIV` cycles between bytes. Slot total = 272 cycles at default.
- Init phase: `RST_LOW` + `RST_WAIT` + 6 × 272 = 21,632 cycles at default. `IDLE` is reached before cycle 34,800.
- Frame: 506 bytes × 272 = 137,632 cycles from the accepted `draw` edge (+2 synchronizer, +1 edge-detect cycles) to the `done` pulse.
- `done` is high exactly one cycle, registered, after the last `sce` rise.
- Reset mid-operation: all outputs return to reset values immediately (asynchronous). The sequence restarts from `RST_LOW`. `pattern` clears to 0.

## Structure
- Package `lcd5110_pkg` holds:
  - FSM state enum;
  - init command constants (0x21, 0xB1, 0x04, 0x14, 0x20, 0x0C, 0x80, 0x40);
  - `FRAME_BYTES`=504.
- Sub-module `spi_byte_tx`:
  - inputs: `clk`, `rst_n`, `start`, `byte_in[7:0]`, `dc_in`;
  - outputs: `busy`, `byte_done`, `sce`, `dc`, `mosi`, `sck`;
  - owns the `CLK_DIV` counter, bit counter and inter-byte gap.
- The top holds the FSM, delay counters, synchronizers, byte index and pattern mux.

## Test plan
- Reset check: release `rst_n` → `rst_lcd`=0 for 10000 cycles, then 1. `sce`=1 throughout. No `sck` activity during `RST_LOW`/`RST_WAIT`.
- Init stream: decode the SPI stream → exactly 0x21, 0xB1, 0x04, 0x14, 0x20, 0x0C with `dc`=0. `sck` period 32 cycles, `mosi` stable around each rise.
- Frame: at 348,155 ns set `switches`=0x8000; pulse `draw` high 4096 cycles → bytes 0x80, 0x40 (`dc`=0), then 504 bytes alternating 0x80, 0x00 (`dc`=1). One `done` pulse ~137,632 cycles after the edge.
- Switch change mid-frame: change `switches` to 0xFFFF during `FRAME` → frame still 0x80/0x00. The next `draw` yields 0xFF for all 504 bytes.
- Ignored request: pulse `draw` during init and again mid-frame → no extra frame, exactly one `done` per accepted edge.
- Mid-frame reset: assert `rst_n`=0 at byte 200 → `sce`=1, `sck`=0, `rst_lcd`=0 immediately. The full init sequence repeats after release.
